// File: rtl/util_fifo.sv
// util_fifo: single-clock FIFO for 64-bit instruction words between the
// fetch/DMA front end and the ISA decoder. Registered full/empty flags and
// registered read data. Writes to a full FIFO and reads from an empty FIFO
// are dropped with no state change.
// Optional status outputs (count, overflow, underflow) are built when the
// macro UTIL_FIFO_STATUS_EN is defined.
// rst_n is an asynchronous ACTIVE-HIGH reset (name kept from the codebase).
module util_fifo #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] din,
   output logic                  full,
   output logic                  empty,
`ifdef UTIL_FIFO_STATUS_EN
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow,
`endif
   output logic [DATA_WIDTH-1:0] dout
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned PW    = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr_nxt_c;
   logic [PW-1:0]         rd_ptr_nxt_c;
   logic                  rd_accept_c;
   logic                  wr_accept_c;
   logic                  empty_nxt_c;
   logic                  full_nxt_c;

   // Accept decisions and next pointer/flag values from registered state
   always_comb begin
      rd_accept_c  = rd_en & ~empty;
      wr_accept_c  = wr_en & (~full | rd_accept_c);
      wr_ptr_nxt_c = wr_ptr + PW'(wr_accept_c);
      rd_ptr_nxt_c = rd_ptr + PW'(rd_accept_c);
      empty_nxt_c  = (wr_ptr_nxt_c == rd_ptr_nxt_c);
      full_nxt_c   = (wr_ptr_nxt_c[ADDR_WIDTH-1:0] == rd_ptr_nxt_c[ADDR_WIDTH-1:0]) &&
                     (wr_ptr_nxt_c[ADDR_WIDTH] != rd_ptr_nxt_c[ADDR_WIDTH]);
   end

   // Storage array, intentionally not reset
   always_ff @(posedge clk) begin
      if (wr_accept_c) begin
         mem[wr_ptr[ADDR_WIDTH-1:0]] <= din;
      end
   end

   // Pointers, flags and read data register
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
         dout   <= '0;
      end else begin
         wr_ptr <= wr_ptr_nxt_c;
         rd_ptr <= rd_ptr_nxt_c;
         empty  <= empty_nxt_c;
         full   <= full_nxt_c;
         if (rd_accept_c) begin
            dout <= mem[rd_ptr[ADDR_WIDTH-1:0]];
         end
      end
   end

`ifdef UTIL_FIFO_STATUS_EN
   // Occupancy count and sticky drop indicators
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         count <= wr_ptr_nxt_c - rd_ptr_nxt_c;
         if (wr_en && !wr_accept_c) begin
            overflow <= 1'b1;
         end
         if (rd_en && !rd_accept_c) begin
            underflow <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_util_fifo.sv
// Directed self-checking bench for util_fifo (status checks included when
// UTIL_FIFO_STATUS_EN is defined).
module tb_util_fifo;

   localparam int unsigned DW = 64;
   localparam int unsigned AW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic [DW-1:0] din = '0;
   logic          full;
   logic          empty;
   logic [DW-1:0] dout;
`ifdef UTIL_FIFO_STATUS_EN
   logic [AW:0]   count;
   logic          overflow;
   logic          underflow;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   logic [DW-1:0] q[$];
   logic [DW-1:0] exp_v;

   util_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .rd_en     (rd_en),
      .din       (din),
      .full      (full),
      .empty     (empty),
`ifdef UTIL_FIFO_STATUS_EN
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow),
`endif
      .dout      (dout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One clock with the given request; inputs return to idle 1ns after the edge
   task automatic cyc(input logic we, input logic re, input logic [DW-1:0] d);
      wr_en = we;
      rd_en = re;
      din   = d;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      din   = '0;
   endtask

   initial begin
      // Async reset takes effect immediately, before any clock edge
      #1 rst_n = 1'b1;
      #1;
      check("rst_empty", 64'(empty), 64'd1);
      check("rst_full",  64'(full),  64'd0);
      check("rst_dout",  dout,       64'd0);
`ifdef UTIL_FIFO_STATUS_EN
      check("rst_count", 64'(count), 64'd0);
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      cyc(1'b0, 1'b0, '0);
      check("hold_empty", 64'(empty), 64'd1);
      check("hold_full",  64'(full),  64'd0);

      // Fill with 1..8 on alternating cycles
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b1, 1'b0, 64'(i));
         check($sformatf("fill_empty_%0d", i), 64'(empty), 64'd0);
         check($sformatf("fill_full_%0d", i),  64'(full), (i == 8) ? 64'd1 : 64'd0);
         cyc(1'b0, 1'b0, '0);
      end
`ifdef UTIL_FIFO_STATUS_EN
      check("fill_count", 64'(count), 64'd8);
      check("fill_ovf",   64'(overflow), 64'd0);
`endif

      // Dropped write while full
      cyc(1'b1, 1'b0, 64'd4095);
      check("ovf_full", 64'(full), 64'd1);
      check("ovf_dout", dout, 64'd0);
`ifdef UTIL_FIFO_STATUS_EN
      check("ovf_flag",  64'(overflow), 64'd1);
      check("ovf_count", 64'(count), 64'd8);
`endif

      // Drain: 1..8 in order, one cycle latency
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b0, 1'b1, '0);
         check($sformatf("drain_dout_%0d", i), dout, 64'(i));
         check($sformatf("drain_full_%0d", i), 64'(full), 64'd0);
         check($sformatf("drain_empty_%0d", i), 64'(empty), (i == 8) ? 64'd1 : 64'd0);
      end

      // Dropped read while empty
      cyc(1'b0, 1'b1, '0);
      check("udf_dout",  dout, 64'd8);
      check("udf_empty", 64'(empty), 64'd1);
`ifdef UTIL_FIFO_STATUS_EN
      check("udf_flag",  64'(underflow), 64'd1);
      check("udf_count", 64'(count), 64'd0);
`endif

      // Simultaneous read+write at full
      for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 64'(i));
      check("cc_full_pre", 64'(full), 64'd1);
      cyc(1'b1, 1'b1, 64'd9);
      check("cc_dout", dout, 64'd1);
      check("cc_full", 64'(full), 64'd1);
      for (int i = 2; i <= 9; i++) begin
         cyc(1'b0, 1'b1, '0);
         check($sformatf("cc_rd_%0d", i), dout, 64'(i));
      end
      check("cc_empty", 64'(empty), 64'd1);

      // Twelve writes across the pointer wrap, reading on odd iterations
      for (int k = 0; k < 12; k++) begin
         if (k % 2 == 1) begin
            exp_v = q.pop_front();
            q.push_back(64'(100 + k));
            cyc(1'b1, 1'b1, 64'(100 + k));
            check($sformatf("wrap_rw_%0d", k), dout, exp_v);
         end else begin
            q.push_back(64'(100 + k));
            cyc(1'b1, 1'b0, 64'(100 + k));
         end
      end
      check("wrap_full", 64'(full), 64'd0);
      while (q.size() > 0) begin
         exp_v = q.pop_front();
         cyc(1'b0, 1'b1, '0);
         check("wrap_drain", dout, exp_v);
      end
      check("wrap_empty", 64'(empty), 64'd1);

      // Mid-operation reset with three words stored
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 64'(200 + i));
      check("mid_pre_empty", 64'(empty), 64'd0);
      #2 rst_n = 1'b1;
      #1;
      check("mid_empty", 64'(empty), 64'd1);
      check("mid_full",  64'(full),  64'd0);
      check("mid_dout",  dout,       64'd0);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      cyc(1'b1, 1'b0, 64'd77);
      check("mid_wr_empty", 64'(empty), 64'd0);
      cyc(1'b0, 1'b1, '0);
      check("mid_rd_dout",  dout, 64'd77);
      check("mid_rd_empty", 64'(empty), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/util_fifo.md
# util_fifo

Synchronous single-clock FIFO buffering 64-bit instruction words between the instruction fetch/DMA front end and the ISA decoder. Writes and reads share one clock. Full and empty flags are registered, and the read data port is registered. Writes to a full FIFO and reads from an empty FIFO are dropped without corrupting state.

## Interface
Parameters:
- DATA_WIDTH, 64, word width of din/dout
- ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH = 8 entries

Ports:
- clk  input  1  rising-edge clock for all state
- rst_n  input  1  asynchronous, active-high reset (port keeps the codebase name rst_n; asserted = 1)
- wr_en  input  1  write request; din sampled on the rising edge
- rd_en  input  1  read request
- din  input  DATA_WIDTH  write data
- full  output  1  FIFO holds DEPTH words
- empty  output  1  FIFO holds 0 words
- dout  output  DATA_WIDTH  registered read data

## Operation
- Storage: DEPTH x DATA_WIDTH register array, no reset on the array contents.
- Pointers: wr_ptr and rd_ptr, each ADDR_WIDTH+1 bits, with the MSB as the wrap bit. Low ADDR_WIDTH bits index the array.
- Flags:
  - empty = (wr_ptr == rd_ptr)
  - full = (low bits equal) and (MSBs differ)
  - Flags are driven from registered pointers, with no combinational path from wr_en/rd_en.
- Accepted write: wr_en & (~full | rd_accept). Stores din at wr_ptr, then wr_ptr += 1 (mod 2**(ADDR_WIDTH+1)).
- Accepted read: rd_accept = rd_en & ~empty. Loads dout with mem[rd_ptr], then rd_ptr += 1.
- Dropped write (wr_en while full, no accepted read): no state change.
- Dropped read (rd_en while empty): no state change; dout holds its previous value.
- Simultaneous read+write:
  - Not empty and not full: both accepted, occupancy unchanged.
  - Full: read frees a slot and the write is accepted; full stays 1.
  - Empty: write accepted, read dropped; empty deasserts next cycle.
- Reset (any time, including mid-operation): wr_ptr = rd_ptr = 0, empty = 1, full = 0, dout = 0. Contents are discarded logically.

## Timing
- Write to flag: accepted write at edge N gives empty = 0 after edge N.
- The DEPTH-th outstanding write at edge N gives full = 1 after edge N.
- Read latency is 1 cycle: rd_en accepted at edge N makes dout valid after edge N. dout holds until the next accepted read.
- Reset is asynchronous. Assertion forces outputs immediately. Deassertion is sampled at the next rising edge, and the first write is accepted on that edge.
- No wr_en/rd_en handshake beyond the flags. The producer must check full and the consumer must check empty; violations are dropped as described in Operation.

## Configuration
- Macro UTIL_FIFO_STATUS_EN.
- Defined: adds outputs
  - count (ADDR_WIDTH+1 bits) = wr_ptr - rd_ptr, reset 0
  - overflow (1 bit), sticky: set on a dropped write
  - underflow (1 bit), sticky: set on a dropped read
  - overflow and underflow clear only on reset; both reset to 0.
- Not defined: these ports and their logic are absent. Core FIFO behaviour is identical either way.

## Test plan
- Reset: assert rst_n = 1 with wr_en = rd_en = 0 → empty = 1, full = 0, dout = 0 immediately. Hold state after release.
- Fill: release reset, write 1..8 on alternating cycles (wr_en pulsed, din = 0 when idle) → empty = 0 after first write, full = 1 after the write of 8.
- Overflow: with FIFO full, write 4095 → dropped, full stays 1 (overflow = 1 when UTIL_FIFO_STATUS_EN). Then read 8 times → dout = 1,2,...,8, one cycle after each rd_en. empty = 1 after the 8th read.
- Underflow: rd_en while empty → dout holds 8, pointers unchanged, empty stays 1 (underflow = 1 when enabled).
- Concurrent at full: fill with 1..8, then assert wr_en = rd_en with din = 9 → dout = 1, full stays 1. Subsequent reads return 2..9.
- Wrap and mid-reset: perform 12 writes interleaved with reads across the pointer wrap, checking order is preserved. Assert reset with 3 words stored → empty = 1 and full = 0 immediately; next write/read returns the new word only.
